// File: rtl/ramp_framer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ramp_framer_pkg
//  Brief    : Shared FMCW parameters, framer state encoding and helpers.
//  Revision : 1.0 - initial release
// ============================================================================
package ramp_framer_pkg;

    // FMCW chain defaults shared with the downsample stage
    localparam int c_FMCW_OW        = 14;
    localparam int c_FMCW_N_SAMPLES = 1024;
    localparam int c_FMCW_SKIP      = 16;

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_SKIP    = 2'd1;
    localparam logic [1:0] c_ST_CAPTURE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE    = c_ST_IDLE,
        ST_SKIP    = c_ST_SKIP,
        ST_CAPTURE = c_ST_CAPTURE
    } state_e;

    function automatic int clog2_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ramp_framer_if.sv
`default_nettype none
// ============================================================================
//  Module   : ramp_framer_if
//  Brief    : Sample input, ramp strobe and framed output stream of the framer.
//  Revision : 1.0 - initial release
// ============================================================================
interface ramp_framer_if
    import ramp_framer_pkg::*;
#(
    parameter int OW        = c_FMCW_OW,
    parameter int N_SAMPLES = c_FMCW_N_SAMPLES
);
    localparam int c_IDX_W = $clog2(N_SAMPLES);

    logic                  ramp_start_i;
    logic                  valid_i;
    logic signed [OW-1:0]  data_i;
    logic                  ready_i;
    logic                  valid_o;
    logic signed [OW-1:0]  data_o;
    logic [c_IDX_W-1:0]    idx_o;
    logic                  last_o;
    logic                  frame_err_o;
    logic                  overflow_o;

    modport slave (
        input  ramp_start_i, valid_i, data_i, ready_i,
        output valid_o, data_o, idx_o, last_o, frame_err_o, overflow_o
    );

    modport master (
        output ramp_start_i, valid_i, data_i, ready_i,
        input  valid_o, data_o, idx_o, last_o, frame_err_o, overflow_o
    );

endinterface
`default_nettype wire

// File: rtl/ramp_framer_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo
//  Brief    : Single-clock FIFO with a registered head; an entry becomes
//             visible one cycle after the edge that writes it.
//  Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    output logic             o_full,
    input  logic             i_rd_en,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);
    localparam int            c_AW      = $clog2(DEPTH);
    localparam logic [c_AW:0] c_PTR_ONE = (c_AW + 1)'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW:0]    r_wr_ptr;
    logic [c_AW:0]    r_rd_ptr;
    logic [c_AW:0]    w_rd_ptr_nxt;
    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic             w_pop;
    logic             w_push;
    logic             w_head_valid;

    assign o_full       = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                          (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign w_pop        = i_rd_en & r_valid;
    assign w_push       = i_wr_en & (~o_full | w_pop);
    assign w_rd_ptr_nxt = w_pop ? (r_rd_ptr + c_PTR_ONE) : r_rd_ptr;
    // Compare against the pre-edge write pointer so a word written this edge
    // is only presented after the following edge.
    assign w_head_valid = (w_rd_ptr_nxt != r_wr_ptr);

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= i_wr_data;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_valid  <= 1'b0;
            r_data   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            r_rd_ptr <= w_rd_ptr_nxt;
            r_valid  <= w_head_valid;
            r_data   <= w_head_valid ? r_mem[w_rd_ptr_nxt[c_AW-1:0]] : '0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule
`default_nettype wire

// File: rtl/ramp_framer.sv
`default_nettype none
// ============================================================================
//  Module   : ramp_framer
//  Brief    : Cuts the decimated FMCW sample stream into fixed-length frames
//             aligned to ramp starts and buffers them for the FFT.
//  Revision : 1.0 - initial release
// ============================================================================
module ramp_framer
    import ramp_framer_pkg::*;
#(
    parameter int OW         = c_FMCW_OW,
    parameter int N_SAMPLES  = c_FMCW_N_SAMPLES,
    parameter int SKIP       = c_FMCW_SKIP,
    parameter int FIFO_DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    ramp_framer_if.slave bus
);
    localparam int c_IDX_W     = $clog2(N_SAMPLES);
    localparam int c_SKIP_W    = clog2_min1(SKIP);
    localparam int c_ENTRY_W   = OW + c_IDX_W + 1;
    localparam int c_SKIP_LAST = (SKIP > 0) ? SKIP - 1 : 0;

    localparam logic [c_SKIP_W-1:0] c_SKIP_END  = c_SKIP_W'(c_SKIP_LAST);
    localparam logic [c_SKIP_W-1:0] c_SKIP_ONE  = c_SKIP_W'(1);
    localparam logic [c_IDX_W-1:0]  c_IDX_LAST  = c_IDX_W'(N_SAMPLES - 1);
    localparam logic [c_IDX_W-1:0]  c_IDX_ONE   = c_IDX_W'(1);
    localparam state_e              c_ENTRY_ST  = (SKIP == 0) ? ST_CAPTURE : ST_SKIP;

    state_e                r_state;
    state_e                w_state_nxt;
    logic [c_SKIP_W-1:0]   r_skip_cnt;
    logic [c_SKIP_W-1:0]   w_skip_nxt;
    logic [c_IDX_W-1:0]    r_sample_cnt;
    logic [c_IDX_W-1:0]    w_sample_nxt;
    logic                  w_wr_req;
    logic                  w_last;
    logic                  w_wr_en;
    logic                  w_rd_en;
    logic                  w_full;
    logic                  w_ovf_set;
    logic                  r_frame_err;
    logic                  r_overflow;
    logic                  w_fifo_valid;
    logic [c_ENTRY_W-1:0]  w_fifo_dout;

    // A ramp start always wins over a coincident sample and restarts the frame.
    always_comb begin
        w_state_nxt  = r_state;
        w_skip_nxt   = r_skip_cnt;
        w_sample_nxt = r_sample_cnt;
        w_wr_req     = 1'b0;
        w_last       = 1'b0;
        if (bus.ramp_start_i) begin
            w_state_nxt  = c_ENTRY_ST;
            w_skip_nxt   = '0;
            w_sample_nxt = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_skip_nxt   = '0;
                    w_sample_nxt = '0;
                end
                ST_SKIP: begin
                    if (bus.valid_i) begin
                        if (r_skip_cnt == c_SKIP_END) begin
                            w_state_nxt = ST_CAPTURE;
                            w_skip_nxt  = '0;
                        end else begin
                            w_skip_nxt  = r_skip_cnt + c_SKIP_ONE;
                        end
                    end
                end
                ST_CAPTURE: begin
                    if (bus.valid_i) begin
                        w_wr_req = 1'b1;
                        w_last   = (r_sample_cnt == c_IDX_LAST);
                        if (w_last) begin
                            w_state_nxt  = ST_IDLE;
                            w_sample_nxt = '0;
                        end else begin
                            w_sample_nxt = r_sample_cnt + c_IDX_ONE;
                        end
                    end
                end
                default: begin
                    w_state_nxt  = ST_IDLE;
                    w_skip_nxt   = '0;
                    w_sample_nxt = '0;
                end
            endcase
        end
    end

    // A full FIFO still accepts the write when the head leaves on the same edge.
    assign w_rd_en   = w_fifo_valid & bus.ready_i;
    assign w_wr_en   = w_wr_req & (~w_full | w_rd_en);
    assign w_ovf_set = w_wr_req & w_full & ~w_rd_en;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= ST_IDLE;
            r_skip_cnt   <= '0;
            r_sample_cnt <= '0;
            r_frame_err  <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_skip_cnt   <= w_skip_nxt;
            r_sample_cnt <= w_sample_nxt;
            r_frame_err  <= bus.ramp_start_i & (r_state != ST_IDLE);
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end
        end
    end

    sync_fifo #(
        .WIDTH (c_ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .i_wr_en   (w_wr_en),
        .i_wr_data ({bus.data_i, r_sample_cnt, w_last}),
        .o_full    (w_full),
        .i_rd_en   (bus.ready_i),
        .o_valid   (w_fifo_valid),
        .o_data    (w_fifo_dout)
    );

    assign bus.valid_o     = w_fifo_valid;
    assign bus.data_o      = w_fifo_dout[c_ENTRY_W-1 -: OW];
    assign bus.idx_o       = w_fifo_dout[c_IDX_W:1];
    assign bus.last_o      = w_fifo_dout[0];
    assign bus.frame_err_o = r_frame_err;
    assign bus.overflow_o  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_ramp_framer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ramp_framer
//  Brief    : Directed bench for ramp_framer (SKIP=2 and SKIP=0 instances).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ramp_framer;
    localparam int OW    = 14;
    localparam int N     = 8;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ramp_framer_if #(.OW(OW), .N_SAMPLES(N)) ia ();
    ramp_framer_if #(.OW(OW), .N_SAMPLES(N)) ib ();

    ramp_framer #(.OW(OW), .N_SAMPLES(N), .SKIP(2), .FIFO_DEPTH(DEPTH)) dut_a (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (ia.slave)
    );

    ramp_framer #(.OW(OW), .N_SAMPLES(N), .SKIP(0), .FIFO_DEPTH(DEPTH)) dut_b (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (ib.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int qa_dat[$], qa_idx[$], qa_last[$];
    int qb_dat[$], qb_idx[$], qb_last[$];
    int ex_dat[$], ex_idx[$], ex_last[$];
    int fe_a = 0;
    int fe_b = 0;
    int prev;
    int base;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Record handshakes that will complete at the coming edge, then advance.
    task automatic step();
        if (ia.valid_o === 1'b1 && ia.ready_i === 1'b1) begin
            qa_dat.push_back(int'(ia.data_o));
            qa_idx.push_back(int'(ia.idx_o));
            qa_last.push_back(int'(ia.last_o));
        end
        if (ib.valid_o === 1'b1 && ib.ready_i === 1'b1) begin
            qb_dat.push_back(int'(ib.data_o));
            qb_idx.push_back(int'(ib.idx_o));
            qb_last.push_back(int'(ib.last_o));
        end
        if (ia.frame_err_o === 1'b1) fe_a++;
        if (ib.frame_err_o === 1'b1) fe_b++;
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input int sel, input logic ramp, input logic vld, input int d);
        if (sel == 0) begin
            ia.ramp_start_i = ramp; ia.valid_i = vld; ia.data_i = OW'(d);
        end else begin
            ib.ramp_start_i = ramp; ib.valid_i = vld; ib.data_i = OW'(d);
        end
        step();
        if (sel == 0) begin
            ia.ramp_start_i = 1'b0; ia.valid_i = 1'b0;
        end else begin
            ib.ramp_start_i = 1'b0; ib.valid_i = 1'b0;
        end
    endtask

    // One decimated sample every fourth cycle.
    task automatic feed(input int sel, input int first, input int count);
        for (int k = 0; k < count; k++) begin
            repeat (3) step();
            cyc(sel, 1'b0, 1'b1, first + k);
        end
    endtask

    task automatic exp_frame(input int base_data, input int first_idx, input int count);
        for (int k = 0; k < count; k++) begin
            ex_dat.push_back(base_data + k);
            ex_idx.push_back(first_idx + k);
            ex_last.push_back((first_idx + k == N - 1) ? 1 : 0);
        end
    endtask

    task automatic check_queue(input int sel, input string tag);
        int d[$], x[$], l[$];
        int n;
        if (sel == 0) begin d = qa_dat; x = qa_idx; l = qa_last; end
        else          begin d = qb_dat; x = qb_idx; l = qb_last; end
        chk({tag, "_count"}, d.size(), ex_dat.size());
        n = (d.size() < ex_dat.size()) ? d.size() : ex_dat.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_data[%0d]", tag, i), d[i], ex_dat[i]);
            chk($sformatf("%s_idx[%0d]", tag, i), x[i], ex_idx[i]);
            chk($sformatf("%s_last[%0d]", tag, i), l[i], ex_last[i]);
        end
        ex_dat.delete(); ex_idx.delete(); ex_last.delete();
        if (sel == 0) begin qa_dat.delete(); qa_idx.delete(); qa_last.delete(); end
        else          begin qb_dat.delete(); qb_idx.delete(); qb_last.delete(); end
    endtask

    initial begin
        rst = 1'b1;
        ia.ramp_start_i = 1'b0; ia.valid_i = 1'b0; ia.data_i = '0; ia.ready_i = 1'b0;
        ib.ramp_start_i = 1'b0; ib.valid_i = 1'b0; ib.data_i = '0; ib.ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", ia.valid_o, 0);
        chk("rst_data", ia.data_o, 0);
        chk("rst_idx", ia.idx_o, 0);
        chk("rst_last", ia.last_o, 0);
        chk("rst_ferr", ia.frame_err_o, 0);
        chk("rst_ovf", ia.overflow_o, 0);
        rst = 1'b0;
        step();

        // Basic frame: SKIP=2, samples 2..9 become idx 0..7
        ia.ready_i = 1'b1;
        cyc(0, 1'b1, 1'b0, 0);
        feed(0, 0, 3);
        chk("lat_edge_k", ia.valid_o, 0);
        step();
        chk("lat_edge_k1", ia.valid_o, 1);
        chk("lat_data", ia.data_o, 2);
        chk("lat_idx", ia.idx_o, 0);
        feed(0, 3, 7);
        repeat (6) step();
        exp_frame(2, 0, 8);
        check_queue(0, "frame1");
        chk("frame1_no_ferr", fe_a, 0);
        chk("frame1_no_ovf", ia.overflow_o, 0);

        // Abort after 3 captured samples, then a full frame
        cyc(0, 1'b1, 1'b0, 0);
        feed(0, 100, 5);
        cyc(0, 1'b1, 1'b0, 0);
        chk("abort_ferr_hi", ia.frame_err_o, 1);
        step();
        chk("abort_ferr_lo", ia.frame_err_o, 0);
        feed(0, 200, 10);
        repeat (6) step();
        exp_frame(102, 0, 3);
        exp_frame(202, 0, 8);
        check_queue(0, "abort");
        chk("abort_ferr_count", fe_a, 1);

        // Back-pressure: ready low for the whole frame
        ia.ready_i = 1'b0;
        cyc(0, 1'b1, 1'b0, 0);
        feed(0, 300, 10);
        chk("bp_valid", ia.valid_o, 1);
        chk("bp_idx", ia.idx_o, 0);
        chk("bp_data", ia.data_o, 302);
        chk("bp_ovf", ia.overflow_o, 1);
        repeat (5) step();
        chk("bp_hold_data", ia.data_o, 302);
        chk("bp_hold_idx", ia.idx_o, 0);
        chk("bp_hold_last", ia.last_o, 0);
        ia.ready_i = 1'b1;
        repeat (6) step();
        exp_frame(302, 0, 4);
        check_queue(0, "bp");
        chk("bp_drained", ia.valid_o, 0);
        chk("bp_ovf_sticky", ia.overflow_o, 1);

        // Asynchronous reset with data pending
        ia.ready_i = 1'b0;
        cyc(0, 1'b1, 1'b0, 0);
        feed(0, 400, 4);
        step();
        chk("arst_pre_valid", ia.valid_o, 1);
        #3 rst = 1'b1;
        #1;
        chk("arst_valid", ia.valid_o, 0);
        chk("arst_data", ia.data_o, 0);
        chk("arst_idx", ia.idx_o, 0);
        chk("arst_last", ia.last_o, 0);
        chk("arst_ferr", ia.frame_err_o, 0);
        chk("arst_ovf", ia.overflow_o, 0);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        ia.ready_i = 1'b1;
        feed(0, 500, 4);
        repeat (4) step();
        chk("arst_idle_count", qa_dat.size(), 0);
        chk("arst_idle_valid", ia.valid_o, 0);

        // SKIP=0: coincident ramp/sample drops the sample
        ib.ready_i = 1'b1;
        cyc(1, 1'b1, 1'b1, 50);
        feed(1, 51, 8);
        repeat (6) step();
        exp_frame(51, 0, 8);
        check_queue(1, "skip0");
        chk("skip0_no_ferr", fe_b, 0);

        // Full-rate samples with random back-pressure; data stays tied to idx
        for (int f = 0; f < 3; f++) begin
            rst = 1'b1;
            step();
            rst = 1'b0;
            step();
            qa_dat.delete(); qa_idx.delete(); qa_last.delete();
            base = 1000 * (f + 1);
            ia.ready_i = 1'b1;
            cyc(0, 1'b1, 1'b0, 0);
            for (int k = 0; k < 10; k++) begin
                ia.ready_i = 1'($urandom_range(0, 1));
                cyc(0, 1'b0, 1'b1, base + k);
            end
            ia.ready_i = 1'b1;
            repeat (8) step();
            prev = -1;
            for (int i = 0; i < qa_dat.size(); i++) begin
                chk($sformatf("rnd%0d_data[%0d]", f, i), qa_dat[i], base + 2 + qa_idx[i]);
                chk($sformatf("rnd%0d_order[%0d]", f, i), (qa_idx[i] > prev), 1);
                chk($sformatf("rnd%0d_last[%0d]", f, i), qa_last[i], (qa_idx[i] == N - 1));
                prev = qa_idx[i];
            end
            if (ia.overflow_o === 1'b0) begin
                chk($sformatf("rnd%0d_count", f), qa_dat.size(), N);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
